// File: rtl/qspi_pkg.sv
// Shared encodings for the QSPI phase sequencer: FSM states, phase type codes
// presented to the shifter, and the width of the chip-select timing counter.
package qspi_pkg;

  localparam int CNT_W = 4;

  localparam logic [2:0] PHY_INST  = 3'd0;
  localparam logic [2:0] PHY_ADDR  = 3'd1;
  localparam logic [2:0] PHY_DUMMY = 3'd2;
  localparam logic [2:0] PHY_WDATA = 3'd3;
  localparam logic [2:0] PHY_RDATA = 3'd4;

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_LOAD  = 4'd1,
    S_SETUP = 4'd2,
    S_INST  = 4'd3,
    S_ADDR  = 4'd4,
    S_DUMMY = 4'd5,
    S_DATA  = 4'd6,
    S_HOLD  = 4'd7,
    S_GAP   = 4'd8
  } state_t;

endpackage

// File: rtl/qspi_cs_timer.sv
// Small load/decrement counter used for chip-select setup, hold and idle gap.
// Load has priority over decrement; the count saturates at zero.
module qspi_cs_timer
  import qspi_pkg::*;
(
  input  logic             clock,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_one
);

  logic [CNT_W-1:0] r_cnt;

  // Counter register: load a new interval or count it down.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_one = (r_cnt == CNT_W'(1));

endmodule

// File: rtl/qspi_phase_seq.sv
// QSPI phase sequencer: walks INST -> ADDR -> DUMMY -> DATA, issuing one
// request per phase to the shifter, and owns chip-select timing around the
// command. io_state_free tells the command generator it may capture again.
module qspi_phase_seq
  import qspi_pkg::*;
#(
  parameter int unsigned CS_SETUP = 1,
  parameter int unsigned CS_HOLD  = 1,
  parameter int unsigned CS_IDLE  = 2
) (
  input  logic        clock,
  input  logic        rst_n,
  input  logic        io_cmd_fire,
  output logic        io_state_free,
  input  logic [7:0]  io_inst,
  input  logic [23:0] io_addr,
  input  logic        io_addr_valid,
  input  logic        io_dummy_valid,
  input  logic        io_wr_valid,
  input  logic        io_rd_valid,
  input  logic [3:0]  io_inst_size,
  input  logic [3:0]  io_addr_size,
  input  logic [3:0]  io_dummy_size,
  input  logic [3:0]  io_data_size,
  input  logic [7:0]  io_inst_burstlen,
  input  logic [7:0]  io_addr_burstlen,
  input  logic [7:0]  io_dummy_burstlen,
  input  logic [7:0]  io_data_burstlen,
  output logic        io_phy_req_valid,
  input  logic        io_phy_req_ready,
  output logic [2:0]  io_phy_req_type,
  output logic [3:0]  io_phy_req_size,
  output logic [7:0]  io_phy_req_burstlen,
  output logic [23:0] io_phy_req_data,
  input  logic        io_phy_done,
  output logic        io_cs_n,
  output logic        io_cmd_done
);

  localparam logic [CNT_W-1:0] LP_SETUP = CNT_W'(CS_SETUP);
  localparam logic [CNT_W-1:0] LP_HOLD  = CNT_W'(CS_HOLD);
  localparam logic [CNT_W-1:0] LP_IDLE  = CNT_W'(CS_IDLE);

  state_t r_state;
  state_t w_state_next;
  state_t w_after_state;
  state_t w_load_state;

  logic        r_cs_n;
  logic        r_req_valid;
  logic        r_cmd_done;
  logic        r_accepted;
  logic [2:0]  r_req_type;
  logic [3:0]  r_req_size;
  logic [7:0]  r_req_bl;
  logic [23:0] r_req_data;

  // Phase enables captured when the command starts.
  logic r_addr_en;
  logic r_dummy_en;
  logic r_data_en;
  logic r_wr;

  logic             w_cs_n_next;
  logic             w_req_valid_next;
  logic             w_cmd_done_next;
  logic             w_accepted_next;
  logic             w_req_load;
  logic             w_snap;
  logic             w_tmr_load;
  logic [CNT_W-1:0] w_tmr_val;
  logic             w_tmr_dec;
  logic             w_tmr_one;
  logic             w_in_phase;
  logic             w_accept;
  logic             w_phase_done;

  logic [2:0]  w_ld_type;
  logic [3:0]  w_ld_size;
  logic [7:0]  w_ld_bl;
  logic [23:0] w_ld_data;

  qspi_cs_timer u_cs_timer (
    .clock      (clock),
    .rst_n      (rst_n),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .i_dec      (w_tmr_dec),
    .o_one      (w_tmr_one)
  );

  assign w_in_phase   = (r_state == S_INST) || (r_state == S_ADDR) ||
                        (r_state == S_DUMMY) || (r_state == S_DATA);
  assign w_accept     = r_req_valid && io_phy_req_ready;
  // A done only counts once the request was taken, including the accept cycle.
  assign w_phase_done = w_in_phase && io_phy_done && (r_accepted || w_accept);

  // Next enabled phase after the current one; disabled phases cost nothing.
  always_comb begin
    w_after_state = S_HOLD;
    case (r_state)
      S_INST: begin
        if (r_addr_en)       w_after_state = S_ADDR;
        else if (r_dummy_en) w_after_state = S_DUMMY;
        else if (r_data_en)  w_after_state = S_DATA;
      end
      S_ADDR: begin
        if (r_dummy_en)      w_after_state = S_DUMMY;
        else if (r_data_en)  w_after_state = S_DATA;
      end
      S_DUMMY: begin
        if (r_data_en)       w_after_state = S_DATA;
      end
      default: w_after_state = S_HOLD;
    endcase
  end

  assign w_load_state = (r_state == S_SETUP) ? S_INST : w_after_state;

  // Payload for the phase about to be requested; write wins over read.
  always_comb begin
    w_ld_type = PHY_INST;
    w_ld_size = io_inst_size;
    w_ld_bl   = io_inst_burstlen;
    w_ld_data = {16'h0000, io_inst};
    case (w_load_state)
      S_ADDR: begin
        w_ld_type = PHY_ADDR;
        w_ld_size = io_addr_size;
        w_ld_bl   = io_addr_burstlen;
        w_ld_data = io_addr;
      end
      S_DUMMY: begin
        w_ld_type = PHY_DUMMY;
        w_ld_size = io_dummy_size;
        w_ld_bl   = io_dummy_burstlen;
        w_ld_data = '0;
      end
      S_DATA: begin
        w_ld_type = r_wr ? PHY_WDATA : PHY_RDATA;
        w_ld_size = io_data_size;
        w_ld_bl   = io_data_burstlen;
        w_ld_data = '0;
      end
      default: ;
    endcase
  end

  // FSM next-state and next values of the registered control outputs.
  always_comb begin
    w_state_next     = r_state;
    w_cs_n_next      = r_cs_n;
    w_req_valid_next = r_req_valid;
    w_accepted_next  = r_accepted;
    w_cmd_done_next  = 1'b0;
    w_req_load       = 1'b0;
    w_snap           = 1'b0;
    w_tmr_load       = 1'b0;
    w_tmr_val        = LP_SETUP;
    w_tmr_dec        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (io_cmd_fire) w_state_next = S_LOAD;
      end
      S_LOAD: begin
        w_snap       = 1'b1;
        w_cs_n_next  = 1'b0;
        w_tmr_load   = 1'b1;
        w_tmr_val    = LP_SETUP;
        w_state_next = S_SETUP;
      end
      S_SETUP: begin
        w_tmr_dec = 1'b1;
        if (w_tmr_one) begin
          w_state_next     = S_INST;
          w_req_load       = 1'b1;
          w_req_valid_next = 1'b1;
          w_accepted_next  = 1'b0;
        end
      end
      S_INST, S_ADDR, S_DUMMY, S_DATA: begin
        if (w_accept) begin
          w_req_valid_next = 1'b0;
          w_accepted_next  = 1'b1;
        end
        if (w_phase_done) begin
          w_accepted_next = 1'b0;
          if (w_after_state == S_HOLD) begin
            w_state_next = S_HOLD;
            w_tmr_load   = 1'b1;
            w_tmr_val    = LP_HOLD;
          end else begin
            w_state_next     = w_after_state;
            w_req_load       = 1'b1;
            w_req_valid_next = 1'b1;
          end
        end
      end
      S_HOLD: begin
        if (w_tmr_one) begin
          w_cs_n_next     = 1'b1;
          w_cmd_done_next = 1'b1;
          w_tmr_load      = 1'b1;
          w_tmr_val       = LP_IDLE;
          w_state_next    = S_GAP;
        end else begin
          w_tmr_dec = 1'b1;
        end
      end
      S_GAP: begin
        w_tmr_dec = 1'b1;
        if (w_tmr_one) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // State and control output registers; reset aborts any command at once.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cs_n      <= 1'b1;
      r_req_valid <= 1'b0;
      r_accepted  <= 1'b0;
      r_cmd_done  <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_cs_n      <= w_cs_n_next;
      r_req_valid <= w_req_valid_next;
      r_accepted  <= w_accepted_next;
      r_cmd_done  <= w_cmd_done_next;
    end
  end

  // Request payload holds steady from request until the next phase loads.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_req_type <= PHY_INST;
      r_req_size <= '0;
      r_req_bl   <= '0;
      r_req_data <= '0;
    end else if (w_req_load) begin
      r_req_type <= w_ld_type;
      r_req_size <= w_ld_size;
      r_req_bl   <= w_ld_bl;
      r_req_data <= w_ld_data;
    end
  end

  // Capture the phase enables once per command.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_addr_en  <= 1'b0;
      r_dummy_en <= 1'b0;
      r_data_en  <= 1'b0;
      r_wr       <= 1'b0;
    end else if (w_snap) begin
      r_addr_en  <= io_addr_valid;
      r_dummy_en <= io_dummy_valid;
      r_data_en  <= (io_wr_valid || io_rd_valid) && (io_data_burstlen != 8'd0);
      r_wr       <= io_wr_valid;
    end
  end

  assign io_state_free       = (r_state == S_IDLE);
  assign io_cs_n             = r_cs_n;
  assign io_phy_req_valid    = r_req_valid;
  assign io_phy_req_type     = r_req_type;
  assign io_phy_req_size     = r_req_size;
  assign io_phy_req_burstlen = r_req_bl;
  assign io_phy_req_data     = r_req_data;
  assign io_cmd_done         = r_cmd_done;

endmodule
